// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and parity-mode codes.
// Used by the TX controller and intended for the matching RX controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Word handshake between the TX data source (master) and the UART TX controller (slave).
// Frame configuration travels with the word and is sampled on accept.
interface uart_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic [1:0]        parity_mode;
  logic              stop2;

  modport master (output tx_valid, output tx_data, output parity_mode, output stop2,
                  input tx_ready);
  modport slave  (input tx_valid, input tx_data, input parity_mode, input stop2,
                  output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..CLK_PER_BIT-1 and flags the last cycle of each bit.
// A synchronous clear holds the phase at zero so every frame starts on a fresh bit boundary.
module uart_baud_tick #(
  parameter int CLK_PER_BIT = 16,
  parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, DATA_W bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the brk input and the line-break state.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CLK_PER_BIT = 16,
  parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus,
`ifdef UART_TX_BREAK_EN
  input  logic           brk,
`endif
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  uart_state_t       state, state_nx;
  logic              tx_nx;
  logic              tick, baud_clr;
  logic              accept, brk_go, tx_ready, frame_end, last_stop;
  logic              load, shift, stop_inc;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              par_en, par_bit, stop2_q, stop_idx;
`ifdef UART_TX_BREAK_EN
  logic              brk_mark, mark_set;
`endif

  uart_baud_tick #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (tick)
  );

  assign last_stop = !stop2_q || stop_idx;
  assign frame_end = (state == STOP) && tick && last_stop;
  assign tx_ready  = (state == IDLE) || frame_end;
  assign bus.tx_ready = tx_ready;
  assign tx_done   = frame_end;
  assign busy      = (state != IDLE);

  // A pending break wins over a pending word in the same ready cycle.
`ifdef UART_TX_BREAK_EN
  assign brk_go = brk && tx_ready;
  assign accept = bus.tx_valid && tx_ready && !brk;
`else
  assign brk_go = 1'b0;
  assign accept = bus.tx_valid && tx_ready;
`endif

  always_comb begin
    state_nx = state;
    tx_nx    = 1'b1;
    baud_clr = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    stop_inc = 1'b0;
`ifdef UART_TX_BREAK_EN
    mark_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        baud_clr = 1'b1;
        if (brk_go) begin
          state_nx = BREAK;
          tx_nx    = 1'b0;
        end else if (accept) begin
          state_nx = START;
          tx_nx    = 1'b0;
          load     = 1'b1;
        end
      end
      START: begin
        tx_nx = 1'b0;
        if (tick) begin
          state_nx = DATA;
          tx_nx    = shreg[0];
        end
      end
      DATA: begin
        tx_nx = shreg[0];
        if (tick) begin
          if (bit_idx == LAST_IDX) begin
            state_nx = par_en ? PARITY : STOP;
            tx_nx    = par_en ? par_bit : 1'b1;
          end else begin
            shift = 1'b1;
            tx_nx = shreg[1];
          end
        end
      end
      PARITY: begin
        tx_nx = par_bit;
        if (tick) begin
          state_nx = STOP;
          tx_nx    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (!last_stop) begin
            stop_inc = 1'b1;
          end else if (brk_go) begin
            state_nx = BREAK;
            tx_nx    = 1'b0;
          end else if (accept) begin
            state_nx = START;
            tx_nx    = 1'b0;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        // Hold the line low while brk is high, then one full bit time of mark.
        if (!brk_mark) begin
          baud_clr = 1'b1;
          tx_nx    = 1'b0;
          if (!brk) begin
            mark_set = 1'b1;
            tx_nx    = 1'b1;
          end
        end else if (tick) begin
          state_nx = IDLE;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        baud_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tx    <= 1'b1;
    end else begin
      state <= state_nx;
      tx    <= tx_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      bit_idx  <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
    end else if (load) begin
      shreg    <= bus.tx_data;
      bit_idx  <= '0;
      par_en   <= (bus.parity_mode == PAR_EVEN) || (bus.parity_mode == PAR_ODD);
      par_bit  <= (bus.parity_mode == PAR_ODD) ? ~^bus.tx_data : ^bus.tx_data;
      stop2_q  <= bus.stop2;
      stop_idx <= 1'b0;
    end else begin
      if (shift) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + IDX_W'(1);
      end
      if (stop_inc) begin
        stop_idx <= 1'b1;
      end
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brk_mark <= 1'b0;
    end else if (brk_go) begin
      brk_mark <= 1'b0;
    end else if (mark_set) begin
      brk_mark <= 1'b1;
    end
  end
`endif

endmodule
